bus_master_q: RTL and testbench

Parametrised bus master with a queued command front-end. Accepts read/write commands from a local requester into a `FIFO_DEPTH`-entry command FIFO. Executes each command on the shared bus as an address phase followed by a data phase, using a valid/ready handshake. Returns one response per command, with per-phase timeout error reporting. Sits between a local requester and the bus fabric, in the master role of `bus_if`.

---
 rtl/bus_pkg.sv | 25 ++
 rtl/bus_if.sv | 23 ++
 rtl/bus_master_q_cmd_fifo.sv | 63 ++++++
 rtl/bus_master_q.sv | 190 +++++++++++++++++++
 tb/tb_bus_master_q.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types for the queued bus master: FSM state encoding and the command record.
// Default widths here match the bus_master_q parameter defaults.
package bus_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ADDR_PHASE = 2'd1,
        DATA_PHASE = 2'd2,
        RESP       = 2'd3
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } cmd_t;

    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bus_if.sv
// Shared-bus signal bundle: one address phase then one data phase, each closed by bus_ready.
interface bus_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32
);
    logic              bus_valid;
    logic              bus_read;
    logic              bus_write;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_valid, bus_read, bus_write, bus_addr, bus_wdata,
        input  bus_ready, bus_rdata
    );

    modport slave (
        input  bus_valid, bus_read, bus_write, bus_addr, bus_wdata,
        output bus_ready, bus_rdata
    );
endinterface

// File: rtl/bus_master_q_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit so full and empty
// are told apart without a separate occupancy register.
module cmd_fifo
    import bus_pkg::*;
#(
    parameter type         entry_t = cmd_t,
    parameter int unsigned DEPTH   = 4,
    localparam int unsigned PTR_W  = ptr_width(DEPTH)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           push,
    input  entry_t         push_data,
    input  logic           pop,
    output entry_t         head,
    output logic           full,
    output logic           empty,
    output logic [PTR_W:0] count
);

    entry_t         mem [DEPTH];
    logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
    logic           do_push;
    logic           do_pop;

    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Storage carries no reset so it can map onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/bus_master_q.sv
// Queued bus master: buffers requester commands and runs each as an address phase
// plus a data phase on bus_if, returning one response strobe per command.
module bus_master_q
    import bus_pkg::*;
#(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    bus_if.master             bus
);

    localparam int unsigned PTR_W = ptr_width(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mcmd_t;

    mcmd_t          push_cmd;
    mcmd_t          head_cmd;
    logic           fifo_full;
    logic           fifo_empty;
    logic [PTR_W:0] fifo_count;
    logic           have_cmd;
    logic           pop;

    state_t            state_q, state_d;
    mcmd_t             cmd_q, cmd_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic              timed_out;
    logic [DATA_W-1:0] rdata_cap;
    logic              in_phase;

    logic              bus_valid_q, bus_valid_d;
    logic              bus_read_q, bus_read_d;
    logic              bus_write_q, bus_write_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    assign push_cmd = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = !fifo_full;
    assign have_cmd  = (fifo_count != '0);

    cmd_fifo #(
        .entry_t (mcmd_t),
        .DEPTH   (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_cmd),
        .pop       (pop && !fifo_empty),
        .head      (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        wait_d    = wait_q;
        pop       = 1'b0;
        timed_out = 1'b0;
        rdata_cap = '0;

        unique case (state_q)
            IDLE: begin
                if (have_cmd) begin
                    pop     = 1'b1;
                    cmd_d   = head_cmd;
                    state_d = ADDR_PHASE;
                end
            end
            ADDR_PHASE: begin
                if (bus.bus_ready) begin
                    state_d = DATA_PHASE;
                end else if (wait_q == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end else if (wait_q != CNT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DATA_PHASE: begin
                if (bus.bus_ready) begin
                    if (!cmd_q.write) begin
                        rdata_cap = bus.bus_rdata;
                    end
                    state_d = RESP;
                end else if (wait_q == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_d   = RESP;
                end else if (wait_q != CNT_MAX) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RESP: begin
                if (have_cmd) begin
                    pop     = 1'b1;
                    cmd_d   = head_cmd;
                    state_d = ADDR_PHASE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            wait_d = '0;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        in_phase    = (state_d == ADDR_PHASE) || (state_d == DATA_PHASE);
        bus_valid_d = in_phase;
        bus_read_d  = in_phase && !cmd_d.write;
        bus_write_d = in_phase && cmd_d.write;
        bus_addr_d  = in_phase ? cmd_d.addr : '0;
        bus_wdata_d = ((state_d == DATA_PHASE) && cmd_d.write) ? cmd_d.wdata : '0;
        rsp_valid_d = (state_d == RESP);
        rsp_write_d = (state_d == RESP) && cmd_d.write;
        rsp_err_d   = (state_d == RESP) && timed_out;
        rsp_rdata_d = (state_d == RESP) ? rdata_cap : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            wait_q      <= '0;
            bus_valid_q <= 1'b0;
            bus_read_q  <= 1'b0;
            bus_write_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            wait_q      <= wait_d;
            bus_valid_q <= bus_valid_d;
            bus_read_q  <= bus_read_d;
            bus_write_q <= bus_write_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_read  = bus_read_q;
    assign bus.bus_write = bus_write_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_write     = rsp_write_q;
    assign rsp_err       = rsp_err_q;
    assign rsp_rdata     = rsp_rdata_q;

endmodule

// File: tb/tb_bus_master_q.sv
// Directed bench for bus_master_q: latency, wait states, FIFO full, timeout,
// back-to-back throughput and reset mid-transaction.
module tb_bus_master_q;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic        rsp_write;
    logic        rsp_err;
    logic [31:0] rsp_rdata;

    logic        ready_tb = 1'b0;
    logic        rdata_fixed_en = 1'b0;
    logic [31:0] rdata_fixed = '0;

    int n_tests = 0;
    int n_fail  = 0;
    logic [33:0] rsp_log [$];

    always #5 clk = ~clk;

    bus_if #(.ADDR_W(16), .DATA_W(32)) bif ();

    assign bif.bus_ready = ready_tb;
    assign bif.bus_rdata = rdata_fixed_en ? rdata_fixed : {16'hA5A5, bif.bus_addr};

    bus_master_q #(
        .ADDR_W     (16),
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .TIMEOUT    (15)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_write (rsp_write),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .bus       (bif)
    );

    always @(posedge clk) begin
        #1;
        if (rsp_valid === 1'b1) begin
            rsp_log.push_back({rsp_write, rsp_err, rsp_rdata});
            $display("[TB] rsp write=%0b err=%0b rdata=%h", rsp_write, rsp_err, rsp_rdata);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic w, input logic [15:0] a, input logic [31:0] d);
        cmd_valid = v;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0]  t3_w;
        logic [33:0] exp_rsp;
        int          nv;

        // Reset state
        step();
        step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_write", rsp_write, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_bus_valid", bif.bus_valid, 0);
        check("rst_bus_read", bif.bus_read, 0);
        check("rst_bus_write", bif.bus_write, 0);
        check("rst_bus_addr", bif.bus_addr, 0);
        check("rst_bus_wdata", bif.bus_wdata, 0);
        reset_n = 1'b1;
        step();

        // Single write, zero wait states: cycle 0 push
        ready_tb = 1'b1;
        set_cmd(1, 1, 16'h0010, 32'hDEADBEEF);
        step();
        set_cmd(0, 0, 16'h0, 32'h0);
        check("t1_c1_bus_valid", bif.bus_valid, 0);
        step();
        check("t1_c2_bus_write", bif.bus_write, 1);
        check("t1_c2_bus_read", bif.bus_read, 0);
        check("t1_c2_bus_addr", bif.bus_addr, 16'h0010);
        check("t1_c2_bus_wdata", bif.bus_wdata, 0);
        step();
        check("t1_c3_bus_write", bif.bus_write, 1);
        check("t1_c3_bus_addr", bif.bus_addr, 16'h0010);
        check("t1_c3_bus_wdata", bif.bus_wdata, 32'hDEADBEEF);
        step();
        check("t1_c4_rsp_valid", rsp_valid, 1);
        check("t1_c4_rsp_write", rsp_write, 1);
        check("t1_c4_rsp_err", rsp_err, 0);
        check("t1_c4_rsp_rdata", rsp_rdata, 0);
        check("t1_c4_bus_valid", bif.bus_valid, 0);
        step();
        check("t1_c5_rsp_valid", rsp_valid, 0);

        // Read with 3 wait states per phase: response at cycle 10
        step();
        rdata_fixed_en = 1'b1;
        rdata_fixed    = 32'h12345678;
        ready_tb       = 1'b0;
        set_cmd(1, 0, 16'h0020, 32'h0);
        for (int c = 1; c <= 10; c++) begin
            step();
            if (c == 1) set_cmd(0, 0, 16'h0, 32'h0);
            ready_tb = (c == 5) || (c == 9);
            if (c == 5) begin
                check("t2_c5_bus_read", bif.bus_read, 1);
                check("t2_c5_bus_addr", bif.bus_addr, 16'h0020);
            end
            if (c == 8) begin
                check("t2_c8_bus_valid", bif.bus_valid, 1);
                check("t2_c8_bus_addr", bif.bus_addr, 16'h0020);
                check("t2_c8_bus_wdata", bif.bus_wdata, 0);
            end
            if (c == 9) check("t2_c9_rsp_valid", rsp_valid, 0);
            if (c == 10) begin
                check("t2_c10_rsp_valid", rsp_valid, 1);
                check("t2_c10_rsp_rdata", rsp_rdata, 32'h12345678);
                check("t2_c10_rsp_err", rsp_err, 0);
                check("t2_c10_rsp_write", rsp_write, 0);
            end
        end
        step();
        ready_tb       = 1'b0;
        rdata_fixed_en = 1'b0;

        // FIFO full: 5 back-to-back pushes while the bus stalls
        step();
        rsp_log.delete();
        t3_w = 5'b10010;
        for (int c = 0; c <= 25; c++) begin
            if (c > 0) step();
            if (c < 5) begin
                check($sformatf("t3_c%0d_cmd_ready", c), cmd_ready, 1);
                set_cmd(1, t3_w[c], 16'h0100 + 16'(c), 32'h0000_0F00 + 32'(c));
            end else if (c == 5) begin
                set_cmd(0, 0, 16'h0, 32'h0);
            end
            ready_tb = (c >= 6);
            if (c >= 5 && c <= 8) check($sformatf("t3_c%0d_cmd_ready", c), cmd_ready, 0);
            if (c == 9) check("t3_c9_cmd_ready", cmd_ready, 1);
        end
        step();
        check("t3_rsp_count", rsp_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < rsp_log.size()) begin
                exp_rsp = t3_w[i] ? {1'b1, 1'b0, 32'h0} : {1'b0, 1'b0, 16'hA5A5, 16'h0100 + 16'(i)};
                check($sformatf("t3_rsp%0d", i), rsp_log[i], exp_rsp);
            end
        end

        // Timeout in ADDR_PHASE, then the queued read runs straight after RESP
        step();
        ready_tb = 1'b0;
        set_cmd(1, 1, 16'h0200, 32'h0000_0055);
        for (int c = 1; c <= 22; c++) begin
            step();
            if (c == 1) set_cmd(1, 0, 16'h0201, 32'h0);
            if (c == 2) set_cmd(0, 0, 16'h0, 32'h0);
            ready_tb = (c >= 18);
            if (c == 16) begin
                check("t4_c16_bus_valid", bif.bus_valid, 1);
                check("t4_c16_rsp_valid", rsp_valid, 0);
            end
            if (c == 17) begin
                check("t4_c17_rsp_valid", rsp_valid, 1);
                check("t4_c17_rsp_err", rsp_err, 1);
                check("t4_c17_rsp_rdata", rsp_rdata, 0);
                check("t4_c17_rsp_write", rsp_write, 1);
                check("t4_c17_bus_valid", bif.bus_valid, 0);
            end
            if (c == 18) begin
                check("t4_c18_bus_valid", bif.bus_valid, 1);
                check("t4_c18_bus_read", bif.bus_read, 1);
                check("t4_c18_bus_addr", bif.bus_addr, 16'h0201);
            end
            if (c == 20) begin
                check("t4_c20_rsp_valid", rsp_valid, 1);
                check("t4_c20_rsp_err", rsp_err, 0);
                check("t4_c20_rsp_rdata", rsp_rdata, 32'hA5A5_0201);
            end
        end

        // Back-to-back writes to 0..3: response every 3 cycles
        step();
        ready_tb = 1'b1;
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) step();
            if (c < 4) set_cmd(1, 1, 16'(c), 32'h0000_1000 + 32'(c));
            else if (c == 4) set_cmd(0, 0, 16'h0, 32'h0);
            if (c >= 2) begin
                check($sformatf("t5_c%0d_rsp_valid", c), rsp_valid,
                      64'((c >= 4) && (c <= 13) && ((c - 4) % 3 == 0)));
            end
            if (c >= 2 && c <= 11 && ((c - 2) % 3 == 0)) begin
                check($sformatf("t5_c%0d_bus_addr", c), bif.bus_addr, 64'((c - 2) / 3));
                check($sformatf("t5_c%0d_bus_write", c), bif.bus_write, 1);
            end
        end

        // Reset in DATA_PHASE with two commands still queued
        step();
        ready_tb = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) step();
            if (c < 3) set_cmd(1, 0, 16'h0400 + 16'(c), 32'h0);
            else set_cmd(0, 0, 16'h0, 32'h0);
            ready_tb = (c == 2);
        end
        check("t6_pre_bus_valid", bif.bus_valid, 1);
        check("t6_pre_cmd_ready", cmd_ready, 1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_bus_valid", bif.bus_valid, 0);
        check("t6_rst_cmd_ready", cmd_ready, 1);
        check("t6_rst_rsp_valid", rsp_valid, 0);
        step();
        step();
        reset_n  = 1'b1;
        ready_tb = 1'b1;
        rsp_log.delete();
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (bif.bus_valid === 1'b1) nv++;
        end
        check("t6_post_bus_valid_cycles", nv, 0);
        check("t6_post_rsp_count", rsp_log.size(), 0);
        set_cmd(1, 1, 16'h0500, 32'hCAFEF00D);
        step();
        set_cmd(0, 0, 16'h0, 32'h0);
        step();
        check("t6_c2_bus_addr", bif.bus_addr, 16'h0500);
        step();
        check("t6_c3_bus_wdata", bif.bus_wdata, 32'hCAFEF00D);
        step();
        check("t6_c4_rsp_valid", rsp_valid, 1);
        check("t6_c4_rsp_write", rsp_write, 1);
        check("t6_c4_rsp_err", rsp_err, 0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
